// File: rtl/spart_tx.sv
// spart_tx: transmit half of the SPART. 8N1 serializer with a holding
// register in front of the shift register, paced by the shared
// oversampling baud tick. tbr reports the holding register empty.
module spart_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1,
  parameter logic [1:0]  TX_ADDR    = 2'b00
) (
  input  logic       rx_clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] tx_data_in,
  output logic       txd,
  output logic       tbr,
  output logic       tx_busy,
  output logic       tx_ovr
);

  localparam int unsigned TICK_W    = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_W     = 3;
  localparam int unsigned DATA_W    = 8;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                tbr_q, tbr_d;
  logic                ovr_q, ovr_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;

  logic                wr_sel;
  logic                bit_end;
  logic                load;

  // Bus write decode and end-of-bit detection
  always_comb begin
    wr_sel  = iocs & ~iorw & (ioaddr == TX_ADDR);
    bit_end = tx_enable & (tick_q == TICK_LAST);
  end

  // Next-state: framing FSM, tick/bit counters, holding register and status
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    tbr_d   = tbr_q;
    ovr_d   = ovr_q;
    load    = 1'b0;

    if (tx_enable) begin
      tick_d = tick_q + TICK_W'(1);
    end

    case (state_q)
      IDLE: begin
        tick_d = '0;
        if (!tbr_q) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tick_d  = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          tick_d  = '0;
          if (bit_q == DATA_LAST) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          tick_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!tbr_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase

    // Hold -> shift transfer starts a new frame with no idle gap
    if (load) begin
      shift_d = hold_q;
      tbr_d   = 1'b1;
      state_d = START;
      tick_d  = '0;
      bit_d   = '0;
    end

    // A transfer needs tbr=0, so a write in that cycle is always an overrun
    if (wr_sel) begin
      if (tbr_q) begin
        hold_d = tx_data_in;
        tbr_d  = 1'b0;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  // Registered outputs derived from the next state
  always_comb begin
    busy_d = (state_d != IDLE);
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  // State and output registers
  always_ff @(posedge rx_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      tbr_q   <= 1'b1;
      ovr_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      tbr_q   <= tbr_d;
      ovr_q   <= ovr_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

  assign txd     = txd_q;
  assign tbr     = tbr_q;
  assign tx_busy = busy_q;
  assign tx_ovr  = ovr_q;

endmodule

// File: tb/tb_spart_tx.sv
// tb_spart_tx: cycle-exact check of spart_tx against a frame-queue model.
module tb_spart_tx;

  localparam int unsigned OS = 16;
  localparam int unsigned SB = 1;

  logic       rx_clk;
  logic       rst;
  logic       tx_enable;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic [7:0] tx_data_in;
  logic       txd;
  logic       tbr;
  logic       tx_busy;
  logic       tx_ovr;

  spart_tx #(
    .OVERSAMPLE(OS),
    .STOP_BITS (SB),
    .TX_ADDR   (2'b00)
  ) dut (
    .rx_clk    (rx_clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .tx_data_in(tx_data_in),
    .txd       (txd),
    .tbr       (tbr),
    .tx_busy   (tx_busy),
    .tx_ovr    (tx_ovr)
  );

  initial begin
    rx_clk = 1'b0;
    forever #5 rx_clk = ~rx_clk;
  end

  // Reference model: queue of serial bit values still to be sent
  bit       m_bits[$];
  int       m_ticks;
  bit [7:0] m_hold;
  bit       m_hold_full;
  bit       m_ovr;

  int vectors;
  int miscompares;
  int cyc;
  int en_mode;
  int busy_cnt;
  int tbr_lo_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_bits.delete();
    m_ticks     = 0;
    m_hold      = 8'h00;
    m_hold_full = 1'b0;
    m_ovr       = 1'b0;
  endfunction

  function automatic void model_start();
    m_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) m_bits.push_back(m_hold[i]);
    for (int i = 0; i < int'(SB); i++) m_bits.push_back(1'b1);
    m_ticks     = 0;
    m_hold_full = 1'b0;
  endfunction

  // Advance the model across one rising edge using the present inputs
  function automatic void model_edge();
    bit hf;
    bit wr;
    if (rst) begin
      model_reset();
      return;
    end
    hf = m_hold_full;
    wr = iocs && !iorw && (ioaddr == 2'b00);
    if (m_bits.size() != 0) begin
      if (tx_enable) begin
        m_ticks++;
        if (m_ticks == int'(OS)) begin
          m_ticks = 0;
          void'(m_bits.pop_front());
        end
      end
      if (m_bits.size() == 0 && hf) model_start();
    end else if (hf) begin
      model_start();
    end
    if (wr) begin
      if (!hf) begin
        m_hold      = tx_data_in;
        m_hold_full = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end
  endfunction

  function automatic logic [3:0] exp_vec();
    logic t;
    t = (m_bits.size() != 0) ? m_bits[0] : 1'b1;
    return {t, ~m_hold_full, (m_bits.size() != 0), m_ovr};
  endfunction

  task automatic tick();
    case (en_mode)
      0:       tx_enable = 1'b1;
      1:       tx_enable = (cyc % 4 == 3);
      default: tx_enable = ($urandom_range(0, 2) == 0);
    endcase
    model_edge();
    @(posedge rx_clk);
    #1;
    cyc++;
    check_eq("txd/tbr/busy/ovr", 32'({txd, tbr, tx_busy, tx_ovr}), 32'(exp_vec()));
    if (tx_busy) busy_cnt++;
    if (!tbr) tbr_lo_cnt++;
  endtask

  task automatic bus(input logic rw, input logic [1:0] addr, input logic [7:0] d);
    iocs       = 1'b1;
    iorw       = rw;
    ioaddr     = addr;
    tx_data_in = d;
    tick();
    iocs       = 1'b0;
    iorw       = 1'b1;
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((m_bits.size() != 0 || m_hold_full) && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_timeout", 32'(n >= budget), 32'(0));
    repeat (2) tick();
  endtask

  task automatic async_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_async", 32'({txd, tbr, tx_busy, tx_ovr}), 32'(4'b1100));
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    en_mode     = 0;
    busy_cnt    = 0;
    tbr_lo_cnt  = 0;
    rst         = 1'b1;
    tx_enable   = 1'b0;
    iocs        = 1'b0;
    iorw        = 1'b1;
    ioaddr      = 2'b00;
    tx_data_in  = 8'h00;
    model_reset();
    #2;
    check_eq("reset_state", 32'({txd, tbr, tx_busy, tx_ovr}), 32'(4'b1100));
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Single frame, tick every cycle
    busy_cnt   = 0;
    tbr_lo_cnt = 0;
    bus(1'b0, 2'b00, 8'hA5);
    run_idle(400);
    check_eq("t1_busy_cycles", 32'(busy_cnt), 32'(160));
    check_eq("t1_tbr_low_cycles", 32'(tbr_lo_cnt), 32'(1));

    // Back-to-back frames
    begin
      int n;
      bus(1'b0, 2'b00, 8'h55);
      n = 0;
      while (!tbr && n < 100) begin
        tick();
        n++;
      end
      check_eq("t2_tbr_timeout", 32'(n >= 100), 32'(0));
      bus(1'b0, 2'b00, 8'hAA);
      run_idle(800);
      check_eq("t2_ovr", 32'(tx_ovr), 32'(0));
    end

    // Overrun: third byte dropped, sticky flag
    bus(1'b0, 2'b00, 8'h11);
    tick();
    bus(1'b0, 2'b00, 8'h22);
    bus(1'b0, 2'b00, 8'h33);
    check_eq("t3_ovr_set", 32'(tx_ovr), 32'(1));
    run_idle(800);
    check_eq("t3_ovr_sticky", 32'(tx_ovr), 32'(1));
    async_reset();
    check_eq("t3_ovr_cleared", 32'(tx_ovr), 32'(0));

    // Reads and other addresses ignored
    busy_cnt   = 0;
    tbr_lo_cnt = 0;
    bus(1'b1, 2'b00, 8'hFF);
    bus(1'b0, 2'b01, 8'hFF);
    bus(1'b1, 2'b01, 8'hFF);
    repeat (20) tick();
    check_eq("t4_busy_cycles", 32'(busy_cnt), 32'(0));
    check_eq("t4_tbr_low_cycles", 32'(tbr_lo_cnt), 32'(0));

    // Reset in the middle of data bit 3, then a clean frame
    bus(1'b0, 2'b00, 8'hC3);
    repeat (1 + 16 + 48 + 8) tick();
    check_eq("t5_mid_frame_busy", 32'(tx_busy), 32'(1));
    async_reset();
    bus(1'b0, 2'b00, 8'h3C);
    run_idle(400);

    // Slow baud tick: every 4th cycle
    en_mode = 1;
    bus(1'b0, 2'b00, 8'h80);
    run_idle(1000);

    // Randomized traffic
    for (int i = 0; i < 8000; i++) begin
      int r;
      if (i % 500 == 0) en_mode = $urandom_range(0, 2);
      r = $urandom_range(0, 999);
      if (r == 0) begin
        async_reset();
      end else if (r < 60) begin
        bus(($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
            8'($urandom));
      end else begin
        tick();
      end
    end
    run_idle(2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
